// File: rtl/mem2k_rd_arbiter.sv
// Read-port arbiter for the 2 KiB mem_2k RAM: DMA-priority reads with CPU anti-starvation, DMA lock,
// tagged in-order returns and a pass-through CPU write port. Optional write-first forwarding: MEM2K_ARB_FWD_EN.
module mem2k_rd_arbiter #(
  parameter int AW       = 11,
  parameter int DW       = 8,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic          dma_req,
  input  logic [AW-1:0] dma_addr,
  input  logic          dma_lock,
  output logic          dma_gnt,
  output logic          dma_rvalid,
  input  logic          cpu_rd_req,
  input  logic [AW-1:0] cpu_addr,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_waddr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] rdata,
  output logic          mem_re,
  output logic [AW-1:0] mem_addrR,
  output logic          mem_we,
  output logic [AW-1:0] mem_addrW,
  output logic [DW-1:0] mem_Din,
  input  logic [DW-1:0] mem_Dout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DMA  = 2'd1,
    S_CPU  = 2'd2
  } state_t;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  state_t      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        override_s;
  logic        dma_gnt_s, cpu_gnt_s;
  logic [RD_LAT-1:0] vld_q;
  logic [RD_LAT-1:0] own_q;   // 1 = CPU owns the read in this stage

  // Winner selection, next owner state and CPU wait counter
  always_comb begin
    override_s = cpu_rd_req & (wait_cnt_q == MAX_WAIT_C) & ~((state_q == S_DMA) & dma_lock);
    dma_gnt_s  = 1'b0;
    cpu_gnt_s  = 1'b0;
    state_d    = S_IDLE;
    wait_cnt_d = wait_cnt_q;
    if (!rstb) begin
      dma_gnt_s = 1'b0;
      cpu_gnt_s = 1'b0;
    end else if (override_s) begin
      cpu_gnt_s = 1'b1;
    end else if (dma_req) begin
      dma_gnt_s = 1'b1;
    end else if (cpu_rd_req) begin
      cpu_gnt_s = 1'b1;
    end else begin
      dma_gnt_s = 1'b0;
    end

    if (dma_gnt_s) begin
      state_d = S_DMA;
    end else if (cpu_gnt_s) begin
      state_d = S_CPU;
    end else begin
      state_d = S_IDLE;
    end

    if (!cpu_rd_req || cpu_gnt_s) begin
      wait_cnt_d = 4'd0;
    end else if (wait_cnt_q != MAX_WAIT_C) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
  end

  assign dma_gnt   = dma_gnt_s;
  assign cpu_gnt   = cpu_gnt_s;
  assign mem_re    = dma_gnt_s | cpu_gnt_s;
  assign mem_addrR = cpu_gnt_s ? cpu_addr : dma_addr;
  assign mem_we    = cpu_we & rstb;
  assign mem_addrW = cpu_waddr;
  assign mem_Din   = cpu_wdata;

  // Read-port owner state and starvation counter
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Tag pipe, one stage per cycle of RAM read latency
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      vld_q <= '0;
      own_q <= '0;
    end else begin
      vld_q[0] <= mem_re;
      own_q[0] <= cpu_gnt_s;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        own_q[i] <= own_q[i-1];
      end
    end
  end

  assign dma_rvalid = vld_q[RD_LAT-1] & ~own_q[RD_LAT-1];
  assign cpu_rvalid = vld_q[RD_LAT-1] &  own_q[RD_LAT-1];

`ifdef MEM2K_ARB_FWD_EN
  logic [RD_LAT-1:0] fwd_vld_q;
  logic [DW-1:0]     fwd_data_q [RD_LAT];
  logic              fwd_hit_s;

  assign fwd_hit_s = mem_re & mem_we & (cpu_waddr == mem_addrR);

  // Forward data rides alongside the tag so a colliding read returns the new value
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      fwd_vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        fwd_data_q[i] <= '0;
      end
    end else begin
      fwd_vld_q[0]  <= fwd_hit_s;
      fwd_data_q[0] <= cpu_wdata;
      for (int i = 1; i < RD_LAT; i++) begin
        fwd_vld_q[i]  <= fwd_vld_q[i-1];
        fwd_data_q[i] <= fwd_data_q[i-1];
      end
    end
  end

  assign rdata = fwd_vld_q[RD_LAT-1] ? fwd_data_q[RD_LAT-1] : mem_Dout;
`else
  assign rdata = mem_Dout;
`endif

endmodule

// File: tb/tb_mem2k_rd_arbiter.sv
// Directed bench for mem2k_rd_arbiter (RD_LAT=2, MAX_WAIT=4) with a read-first RAM model of mem_2k.
module tb_mem2k_rd_arbiter;
  localparam int AW = 11;
  localparam int DW = 8;
  localparam int RD_LAT = 2;
  localparam int MAX_WAIT = 4;

  logic          clk = 1'b0;
  logic          rstb;
  logic          dma_req, dma_lock, cpu_rd_req, cpu_we;
  logic [AW-1:0] dma_addr, cpu_addr, cpu_waddr;
  logic [DW-1:0] cpu_wdata;
  logic          dma_gnt, dma_rvalid, cpu_gnt, cpu_rvalid;
  logic [DW-1:0] rdata;
  logic          mem_re, mem_we;
  logic [AW-1:0] mem_addrR, mem_addrW;
  logic [DW-1:0] mem_Din, mem_Dout;

  int n_checks = 0;
  int n_pass   = 0;

  mem2k_rd_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rstb(rstb),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_lock(dma_lock),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
    .cpu_rd_req(cpu_rd_req), .cpu_addr(cpu_addr),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
    .cpu_we(cpu_we), .cpu_waddr(cpu_waddr), .cpu_wdata(cpu_wdata),
    .rdata(rdata),
    .mem_re(mem_re), .mem_addrR(mem_addrR), .mem_we(mem_we),
    .mem_addrW(mem_addrW), .mem_Din(mem_Din), .mem_Dout(mem_Dout)
  );

  always #5 clk = ~clk;

  // Read-first RAM with two-cycle read latency
  logic [DW-1:0] ram [2048];
  logic [DW-1:0] ram_d1, ram_d2;
  initial begin
    for (int i = 0; i < 2048; i++) ram[i] = 8'h00;
    ram_d1 = 8'h00;
    ram_d2 = 8'h00;
  end
  always @(posedge clk) begin
    if (mem_we) ram[mem_addrW] <= mem_Din;
    if (mem_re) ram_d1 <= ram[mem_addrR];
    ram_d2 <= ram_d1;
  end
  assign mem_Dout = ram_d2;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    dma_req = 1'b0; dma_lock = 1'b0; cpu_rd_req = 1'b0; cpu_we = 1'b0;
    dma_addr = 11'h000; cpu_addr = 11'h000; cpu_waddr = 11'h000; cpu_wdata = 8'h00;
  endtask

  task automatic ram_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    next_cycle();
    idle_inputs();
    cpu_we = 1'b1; cpu_waddr = a; cpu_wdata = d;
    #1;
    check_eq("wr_mem_we", 32'(mem_we), 32'd1);
    check_eq("wr_addrW", 32'(mem_addrW), 32'(a));
  endtask

  initial begin
    logic [7:0] exp_col;
    // Test 1: reset holds everything off
    idle_inputs();
    rstb = 1'b0;
    dma_req = 1'b1; cpu_rd_req = 1'b1; cpu_we = 1'b1;
    dma_addr = 11'h010; cpu_addr = 11'h020; cpu_waddr = 11'h030; cpu_wdata = 8'h55;
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      check_eq("rst_dma_gnt", 32'(dma_gnt), 32'd0);
      check_eq("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
      check_eq("rst_mem_re", 32'(mem_re), 32'd0);
      check_eq("rst_mem_we", 32'(mem_we), 32'd0);
      check_eq("rst_rvalid", 32'({dma_rvalid, cpu_rvalid}), 32'd0);
    end
    next_cycle();
    idle_inputs();
    rstb = 1'b1;

    ram_write(11'h010, 8'hA5);
    ram_write(11'h020, 8'h3C);
    ram_write(11'h7FF, 8'h11);

    // Test 2: DMA priority, then CPU, in-order tagged returns
    next_cycle();
    idle_inputs();
    dma_req = 1'b1; dma_addr = 11'h010; cpu_rd_req = 1'b1; cpu_addr = 11'h020;
    #1;
    check_eq("pri_dma_gnt", 32'(dma_gnt), 32'd1);
    check_eq("pri_cpu_gnt0", 32'(cpu_gnt), 32'd0);
    check_eq("pri_addrR_dma", 32'(mem_addrR), 32'h010);
    next_cycle();
    dma_req = 1'b0;
    #1;
    check_eq("pri_cpu_gnt1", 32'(cpu_gnt), 32'd1);
    check_eq("pri_addrR_cpu", 32'(mem_addrR), 32'h020);
    check_eq("pri_mem_re", 32'(mem_re), 32'd1);
    next_cycle();
    cpu_rd_req = 1'b0;
    check_eq("pri_dma_rvalid", 32'(dma_rvalid), 32'd1);
    check_eq("pri_cpu_rvalid0", 32'(cpu_rvalid), 32'd0);
    check_eq("pri_dma_rdata", 32'(rdata), 32'hA5);
    next_cycle();
    check_eq("pri_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
    check_eq("pri_dma_rvalid0", 32'(dma_rvalid), 32'd0);
    check_eq("pri_cpu_rdata", 32'(rdata), 32'h3C);
    next_cycle();
    check_eq("pri_quiet", 32'({dma_rvalid, cpu_rvalid, mem_re}), 32'd0);

    // Test 3: CPU starvation override on the 5th waiting cycle
    dma_req = 1'b1; dma_addr = 11'h010; cpu_rd_req = 1'b1; cpu_addr = 11'h020;
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) next_cycle();
      if (c == 6) cpu_rd_req = 1'b0;
      #1;
      check_eq($sformatf("starve_dma_gnt_c%0d", c), 32'(dma_gnt), (c == 5) ? 32'd0 : 32'd1);
      check_eq($sformatf("starve_cpu_gnt_c%0d", c), 32'(cpu_gnt), (c == 5) ? 32'd1 : 32'd0);
    end
    next_cycle();
    idle_inputs();
    check_eq("starve_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
    check_eq("starve_cpu_rdata", 32'(rdata), 32'h3C);
    next_cycle();
    check_eq("starve_dma_rvalid", 32'(dma_rvalid), 32'd1);
    check_eq("starve_dma_rdata", 32'(rdata), 32'hA5);

    // Test 4: DMA lock suppresses override until dropped
    next_cycle();
    dma_req = 1'b1; dma_lock = 1'b1; dma_addr = 11'h010; cpu_rd_req = 1'b1; cpu_addr = 11'h020;
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) next_cycle();
      #1;
      check_eq($sformatf("lock_cpu_gnt_c%0d", c), 32'(cpu_gnt), 32'd0);
      check_eq($sformatf("lock_dma_gnt_c%0d", c), 32'(dma_gnt), 32'd1);
    end
    next_cycle();
    dma_lock = 1'b0;
    #1;
    check_eq("unlock_cpu_gnt", 32'(cpu_gnt), 32'd1);
    check_eq("unlock_dma_gnt", 32'(dma_gnt), 32'd0);
    next_cycle();
    idle_inputs();
    next_cycle();
    next_cycle();
    next_cycle();

    // Test 5: same-cycle write/read collision
    dma_req = 1'b1; dma_addr = 11'h7FF;
    cpu_we = 1'b1; cpu_waddr = 11'h7FF; cpu_wdata = 8'h99;
    #1;
    check_eq("col_dma_gnt", 32'(dma_gnt), 32'd1);
    check_eq("col_mem_we", 32'(mem_we), 32'd1);
    next_cycle();
    idle_inputs();
    next_cycle();
`ifdef MEM2K_ARB_FWD_EN
    exp_col = 8'h99;
`else
    exp_col = 8'h11;
`endif
    check_eq("col_rvalid", 32'(dma_rvalid), 32'd1);
    check_eq("col_rdata", 32'(rdata), 32'(exp_col));
    next_cycle();
    cpu_rd_req = 1'b1; cpu_addr = 11'h7FF;
    #1;
    check_eq("col_reread_gnt", 32'(cpu_gnt), 32'd1);
    next_cycle();
    idle_inputs();
    next_cycle();
    check_eq("col_reread_rvalid", 32'(cpu_rvalid), 32'd1);
    check_eq("col_reread_rdata", 32'(rdata), 32'h99);

    // Test 6: reset pulse drops an in-flight tag
    next_cycle();
    dma_req = 1'b1; dma_addr = 11'h010;
    #1;
    check_eq("mid_dma_gnt", 32'(dma_gnt), 32'd1);
    next_cycle();
    idle_inputs();
    rstb = 1'b0;
    #1;
    check_eq("mid_rst_rvalid", 32'({dma_rvalid, cpu_rvalid}), 32'd0);
    next_cycle();
    rstb = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      check_eq($sformatf("mid_no_rvalid_c%0d", c), 32'({dma_rvalid, cpu_rvalid}), 32'd0);
      next_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
